// File: rtl/spram_model_pkg.sv
// Shared types and constants for the single-port RAM model.
// Optional ECC-event injection is enabled by defining SPRAM_MODEL_ECC_INJ_EN.
package spram_model_pkg;

  // Deepest read pipeline the model supports.
  localparam int MAX_RD_LATENCY = 8;

  // Widest data word a read stage can carry; DATA_WIDTH must not exceed it.
  localparam int MAX_DATA_WIDTH = 64;

  // Bits flipped on a double-error read.
  localparam logic [1:0] DERR_MASK = 2'b11;

  typedef enum logic {
    INIT,
    READY
  } state_e;

  // One read-pipeline stage; data is zero-extended to the maximum width.
  typedef struct packed {
    logic                      valid;
    logic [MAX_DATA_WIDTH-1:0] data;
    logic                      corr;
    logic                      derr;
  } rd_stage_t;

endpackage

// File: rtl/spram_model_rd_pipe.sv
// RD_LATENCY-deep read pipeline with asynchronous flush on reset.
// Carries corr/derr tags only when SPRAM_MODEL_ECC_INJ_EN is defined.
module spram_model_rd_pipe
  import spram_model_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  rd_stage_t stage_in,
  output rd_stage_t stage_out
);

  logic [RD_LATENCY-1:0] valid_q;
  logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

  // Shift valid and data one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= stage_in.valid;
      data_q[0]  <= stage_in.data[DATA_WIDTH-1:0];
      for (int i = 1; i < RD_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

`ifdef SPRAM_MODEL_ECC_INJ_EN
  logic [RD_LATENCY-1:0] corr_q;
  logic [RD_LATENCY-1:0] derr_q;

  // Injection tags travel alongside their read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_q <= '0;
      derr_q <= '0;
    end else begin
      corr_q <= {corr_q[RD_LATENCY-1:0] << 1} | RD_LATENCY'(stage_in.corr);
      derr_q <= {derr_q[RD_LATENCY-1:0] << 1} | RD_LATENCY'(stage_in.derr);
    end
  end

  logic unused_in;
  assign unused_in = ^stage_in.data;

  // Present the final stage.
  always_comb begin
    stage_out       = '0;
    stage_out.valid = valid_q[RD_LATENCY-1];
    stage_out.data  = MAX_DATA_WIDTH'(data_q[RD_LATENCY-1]);
    stage_out.corr  = corr_q[RD_LATENCY-1];
    stage_out.derr  = derr_q[RD_LATENCY-1];
  end
`else
  logic unused_in;
  assign unused_in = ^{stage_in.data, stage_in.corr, stage_in.derr};

  // Present the final stage; no tags exist without injection.
  always_comb begin
    stage_out       = '0;
    stage_out.valid = valid_q[RD_LATENCY-1];
    stage_out.data  = MAX_DATA_WIDTH'(data_q[RD_LATENCY-1]);
  end
`endif

endmodule

// File: rtl/spram_model.sv
// Single-port RAM model: post-reset init sweep, fixed read latency and
// optional ECC-event injection (define SPRAM_MODEL_ECC_INJ_EN to enable).
module spram_model
  import spram_model_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    RD_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ecccorr,
  output logic                  eccderr,
  output logic                  init_busy,
  input  logic                  inj_corr,
  input  logic                  inj_derr
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic                  init_we;
  logic                  rd_issue;
  logic                  wr_issue;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  rd_stage_t             stage_in, stage_out;
  logic [DATA_WIDTH-1:0] rd_word;

  // State and sweep pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: sweep every address once, then serve accesses.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_we = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) state_d = READY;
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  assign init_busy = (state_q == INIT);
  assign wr_issue  = (state_q == READY) && cs && we;
  assign rd_issue  = (state_q == READY) && cs && !we;

  // Storage array: the init sweep or a user write, never both in one cycle.
  // NOTE: the array has no reset; the sweep after reset is what initializes it.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[ptr_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
    end else if (wr_issue) begin
      mem[addr] <= wr_data;
    end
  end

  // Build the stage-1 entry for a read issued this cycle.
  always_comb begin
    stage_in       = '0;
    stage_in.valid = rd_issue;
    stage_in.data  = MAX_DATA_WIDTH'(mem[addr]);
`ifdef SPRAM_MODEL_ECC_INJ_EN
    // A double error outranks a corrected error.
    stage_in.derr  = rd_issue & inj_derr;
    stage_in.corr  = rd_issue & inj_corr & ~inj_derr;
`endif
  end

  spram_model_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .stage_in  (stage_in),
    .stage_out (stage_out)
  );

  // Final-stage data, corrupted on an injected double error.
  // NOTE: blocking assignments here so the second line sees the first.
  always_comb begin
    rd_word = stage_out.data[DATA_WIDTH-1:0];
`ifdef SPRAM_MODEL_ECC_INJ_EN
    if (stage_out.derr) rd_word = rd_word ^ DATA_WIDTH'(DERR_MASK);
`endif
  end

  // Read-data hold register: updates only when a read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (stage_out.valid) begin
      rd_data <= rd_word;
    end
  end

`ifdef SPRAM_MODEL_ECC_INJ_EN
  logic unused_bits;
  assign unused_bits = ^stage_out.data;

  // ECC status pulses, one cycle, aligned with the completing read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecccorr <= 1'b0;
      eccderr <= 1'b0;
    end else begin
      ecccorr <= stage_out.valid & stage_out.corr;
      eccderr <= stage_out.valid & stage_out.derr;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{stage_out.data, stage_out.corr, stage_out.derr,
                         inj_corr, inj_derr};

  assign ecccorr = 1'b0;
  assign eccderr = 1'b0;
`endif

endmodule
